// File: rtl/seq_load_packer.sv
// seq_load_packer: packs unaligned AXI read beats of one load into full-width sequential nibble buffers.
module seq_load_packer #(
  parameter int NrLanes      = 4,
  parameter int DLEN         = 64,
  parameter int AxiDataWidth = 128,
  parameter int LenBits      = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  meta_valid_i,
  output logic                                  meta_ready_o,
  input  logic [$clog2(AxiDataWidth/8)-1:0]     meta_off_i,
  input  logic [LenBits-1:0]                    meta_len_i,
  input  logic                                  r_valid_i,
  output logic                                  r_ready_o,
  input  logic [AxiDataWidth-1:0]               r_data_i,
  input  logic                                  r_last_i,
  output logic                                  seq_valid_o,
  input  logic                                  seq_ready_i,
  output logic [NrLanes*DLEN-1:0]               seq_nb_o,
  output logic [NrLanes*DLEN/4-1:0]             seq_en_o,
  output logic                                  err_o
);
  localparam int SeqBytes = NrLanes * DLEN / 8;
  localparam int SeqNbs   = 2 * SeqBytes;
  localparam int AxiBytes = AxiDataWidth / 8;
  localparam int RW       = $clog2(AxiBytes) + 1;
  localparam int PW       = $clog2(SeqBytes) + 1;
  localparam int SW       = SeqBytes * 8;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;
  state_t state, state_n;
  logic [LenBits-1:0] rem, avail, space, take;
  logic [RW-1:0] rd_off;
  logic [PW-1:0] wr_ptr;
  logic [SW-1:0] nb, shifted, bmask;
  logic [SeqNbs-1:0] en, emask;
  logic xfer, pop, done, last, err;

  always_comb begin
    avail = LenBits'(AxiBytes) - LenBits'(rd_off);
    space = LenBits'(SeqBytes) - LenBits'(wr_ptr);
    take = avail < space ? avail : space;
    take = rem < take ? rem : take;
    last = take == rem;
    xfer = state == FILL && r_valid_i;
    pop = xfer && (LenBits'(rd_off) + take == LenBits'(AxiBytes) || last);
    done = xfer && (LenBits'(wr_ptr) + take == LenBits'(SeqBytes) || last);
    // align beat byte rd_off onto buffer byte wr_ptr, then keep only the take-byte window
    shifted = (SW'(r_data_i) >> {rd_off, 3'b0}) << {wr_ptr, 3'b0};
    bmask = '0;
    emask = '0;
    for (int j = 0; j < SeqBytes; j++)
      if (LenBits'(j) >= LenBits'(wr_ptr) && LenBits'(j) < LenBits'(wr_ptr) + take) begin
        bmask[8*j +: 8] = '1;
        emask[2*j +: 2] = '1;
      end
    state_n = state == IDLE ? (meta_valid_i ? FILL : IDLE)
            : state == FILL ? (done ? FLUSH : FILL)
            : seq_ready_i   ? (rem != '0 ? FILL : IDLE) : FLUSH;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rem    <= '0;
      rd_off <= '0;
      wr_ptr <= '0;
      nb     <= '0;
      en     <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && meta_valid_i) begin
        rem    <= meta_len_i;
        rd_off <= RW'(meta_off_i);
        wr_ptr <= '0;
        err    <= err | (meta_len_i == '0);
      end
      if (xfer) begin
        nb     <= nb | (shifted & bmask);
        en     <= en | emask;
        rd_off <= pop ? '0 : rd_off + RW'(take);
        wr_ptr <= wr_ptr + PW'(take);
        rem    <= rem - take;
        err    <= err | (pop && r_last_i != last);
      end
      if (state == FLUSH && seq_ready_i) begin
        nb     <= '0;
        en     <= '0;
        wr_ptr <= '0;
      end
    end
  end

  assign meta_ready_o = state == IDLE && !rst_i;
  assign r_ready_o    = pop && !rst_i;
  assign seq_valid_o  = state == FLUSH && !rst_i;
  assign seq_nb_o     = nb;
  assign seq_en_o     = en;
  assign err_o        = err;
endmodule

// File: tb/tb_seq_load_packer.sv
// tb_seq_load_packer: directed checks of seq_load_packer; beat i byte b carries 16*i+b so memory byte s reads back as s.
module tb_seq_load_packer;
  logic clk = 0, rst = 1;
  logic meta_valid = 0, meta_ready;
  logic [3:0] meta_off = '0;
  logic [15:0] meta_len = '0;
  logic r_valid = 0, r_ready, r_last = 0;
  logic [127:0] r_data = '0;
  logic seq_valid, seq_ready = 0, err;
  logic [255:0] seq_nb;
  logic [63:0] seq_en;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  seq_load_packer dut (
    .clk_i(clk), .rst_i(rst),
    .meta_valid_i(meta_valid), .meta_ready_o(meta_ready),
    .meta_off_i(meta_off), .meta_len_i(meta_len),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_last_i(r_last),
    .seq_valid_o(seq_valid), .seq_ready_i(seq_ready),
    .seq_nb_o(seq_nb), .seq_en_o(seq_en), .err_o(err)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] beat(input int i);
    logic [127:0] d;
    for (int b = 0; b < 16; b++) d[8*b +: 8] = 8'(16 * i + b);
    return d;
  endfunction

  task automatic run_req(input string name, input int off, input int len, input int stall, input bit bad_last);
    int nbeats = (off + len + 15) / 16;
    int nbuf = (len + 31) / 32;
    int bi = 0, q = 0, cyc = 0, n, stall_left = stall;
    bit held = 0;
    logic [255:0] cap_nb, exp_nb;
    logic [63:0] cap_en, exp_en;
    @(posedge clk); #1;
    meta_valid = 1; meta_off = 4'(off); meta_len = 16'(len);
    #4 check({name, "_meta_ready"}, meta_ready, 1);
    while ((bi < nbeats || q < nbuf) && cyc < 300) begin
      @(posedge clk); #1;
      meta_valid = 0;
      cyc++;
      r_valid = bi < nbeats;
      r_data = beat(bi);
      r_last = bad_last ? bi == 0 : bi == nbeats - 1;
      if (seq_valid && stall_left > 0) begin
        seq_ready = 0;
        stall_left--;
      end else seq_ready = 1;
      #4;
      if (seq_valid) begin
        check({name, "_rready_flush"}, r_ready, 0);
        if (!seq_ready) begin
          if (held) begin
            check({name, "_nb_stable"}, seq_nb, cap_nb);
            check({name, "_en_stable"}, seq_en, cap_en);
          end else begin
            held = 1; cap_nb = seq_nb; cap_en = seq_en;
          end
        end else begin
          n = len - 32 * q < 32 ? len - 32 * q : 32;
          exp_nb = '0; exp_en = '0;
          for (int j = 0; j < n; j++) begin
            exp_nb[8*j +: 8] = 8'(off + 32 * q + j);
            exp_en[2*j +: 2] = 2'b11;
          end
          check({name, "_nb"}, seq_nb, exp_nb);
          check({name, "_en"}, seq_en, exp_en);
          q++;
        end
      end
      if (r_valid && r_ready) bi++;
    end
    check({name, "_pops"}, bi, nbeats);
    check({name, "_bufs"}, q, nbuf);
    @(posedge clk); #1;
    r_valid = 0; r_last = 0; seq_ready = 0;
    #4;
    check({name, "_idle"}, meta_ready, 1);
    check({name, "_en_clear"}, seq_en, 0);
    check({name, "_err"}, err, bad_last);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_seq_valid"}, seq_valid, 0);
    check({name, "_r_ready"}, r_ready, 0);
    check({name, "_meta_ready"}, meta_ready, 0);
    check({name, "_nb"}, seq_nb, 0);
    check({name, "_en"}, seq_en, 0);
    check({name, "_err"}, err, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst");
    rst = 0;
    run_req("aligned", 0, 32, 0, 0);
    run_req("misaligned", 4, 16, 0, 0);
    run_req("straddle", 8, 64, 0, 0);
    run_req("backpressure", 0, 48, 5, 0);
    run_req("single", 15, 1, 0, 0);
    run_req("bad_last", 0, 32, 0, 1);
    @(posedge clk); #1;
    meta_valid = 1; meta_off = '0; meta_len = 16'd32;
    @(posedge clk); #1;
    meta_valid = 0; r_valid = 1; r_data = beat(0); seq_ready = 1;
    @(posedge clk); #1;
    r_data = beat(1);
    rst = 1;
    @(posedge clk); #1;
    check_reset_outputs("mid_rst");
    rst = 0; r_valid = 0;
    #4;
    check("mid_rst_idle", meta_ready, 1);
    check("mid_rst_valid_low", seq_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
